uart_rx_frame_ctrl: RTL

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/data_sampler.sv | 33 +++
 rtl/uart_rx_frame_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam logic [5:0] PRESCALE_4  = 6'd4;
   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   function automatic logic prescale_legal(input logic [5:0] p);
      return (p == PRESCALE_4) || (p == PRESCALE_8) ||
             (p == PRESCALE_16) || (p == PRESCALE_32);
   endfunction

   // Mid-bit edge index, P/2.
   function automatic logic [4:0] mid_edge(input logic [5:0] p);
      return 5'(p >> 1);
   endfunction

endpackage

// File: rtl/data_sampler.sv
// Three-point mid-bit sampler with 2-of-3 majority vote on RX_IN.
module data_sampler
   import uart_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       RX_IN,
   input  logic [4:0] edge_cnt,
   input  logic [5:0] Prescale,
   input  logic       cnt_enable,
   output logic       sampled_bit
);

   logic [4:0] w_mid;
   logic       r_s0, r_s1, r_s2;

   assign w_mid = mid_edge(Prescale);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s0 <= 1'b0;
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else if (cnt_enable) begin
         if (edge_cnt == w_mid - 5'd2) r_s0 <= RX_IN;
         if (edge_cnt == w_mid - 5'd1) r_s1 <= RX_IN;
         if (edge_cnt == w_mid)        r_s2 <= RX_IN;
      end
   end

   assign sampled_bit = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame FSM: start/data/parity/stop sequencing, error flags and byte output.
module uart_rx_frame_ctrl
   import uart_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic [5:0] Prescale,
   input  logic [4:0] edge_cnt,
   input  logic [3:0] bit_cnt,
   input  logic [4:0] f_edge,
   output logic       cnt_enable,
   output logic [7:0] P_DATA,
   output logic       data_valid,
   output logic       par_err,
   output logic       stp_err
);

   state_e     r_state;
   logic [7:0] r_shift;
   logic       r_par_en;
   logic       r_par_typ;
   logic       w_sampled;
   logic       w_bit_end;

   data_sampler u_sampler (
      .clk        (clk),
      .rst        (rst),
      .RX_IN      (RX_IN),
      .edge_cnt   (edge_cnt),
      .Prescale   (Prescale),
      .cnt_enable (cnt_enable),
      .sampled_bit(w_sampled)
   );

   assign w_bit_end = cnt_enable && (edge_cnt == f_edge);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         cnt_enable <= 1'b0;
         P_DATA     <= 8'h00;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         r_shift    <= 8'h00;
         r_par_en   <= 1'b0;
         r_par_typ  <= EVEN;
      end else begin
         data_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!RX_IN && prescale_legal(Prescale)) begin
                  r_state    <= START;
                  cnt_enable <= 1'b1;
                  r_par_en   <= PAR_EN;
                  r_par_typ  <= PAR_TYP;
                  par_err    <= 1'b0;
                  stp_err    <= 1'b0;
               end
            end
            START: begin
               if (w_bit_end) begin
                  // A start bit that votes high was line noise, not a frame.
                  if (w_sampled) begin
                     r_state    <= IDLE;
                     cnt_enable <= 1'b0;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_shift <= {w_sampled, r_shift[7:1]};
                  if (bit_cnt == 4'd8) r_state <= r_par_en ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (w_bit_end) begin
                  if (w_sampled != ((^r_shift) ^ r_par_typ)) par_err <= 1'b1;
                  r_state <= STOP;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  stp_err <= ~w_sampled;
                  if (!par_err && w_sampled) begin
                     P_DATA     <= r_shift;
                     data_valid <= 1'b1;
                  end
                  r_state    <= IDLE;
                  cnt_enable <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               cnt_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule
